// File: rtl/fp_norm_round_pkg.sv
// Shared types and constants for the floating-point normalise/round block.
package fp_norm_round_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;

    localparam int EXP_MAX = 255;
    localparam int BIAS    = 127;

    // Leading zeros of a 48-bit vector counted from bit 47 (48 when all zero).
    function automatic logic [5:0] lzc48(input logic [47:0] v);
        lzc48 = 6'd48;
        for (int i = 0; i < 48; i++) begin
            if (v[i]) lzc48 = 6'(47 - i);
        end
    endfunction

endpackage

// File: rtl/fp_norm_round_incr.sv
// Combinational IEEE-754 rounding decision and 24-bit mantissa increment.
module fp_round_incr
    import fp_norm_round_pkg::*;
(
    input  logic [23:0] mant,
    input  logic        guard,
    input  logic        round_bit,
    input  logic        sticky,
    input  logic        sign,
    input  logic [2:0]  rm,
    output logic [23:0] mant_out,
    output logic        mant_carry,
    output logic        inexact
);

    logic        lost;
    logic        incr;
    logic [24:0] sum;

    // Guard is the first dropped bit; round and sticky only break ties.
    always_comb begin
        lost = guard | round_bit | sticky;
        case (rm)
            RM_RTZ:  incr = 1'b0;
            RM_RDN:  incr = sign & lost;
            RM_RUP:  incr = ~sign & lost;
            RM_RMM:  incr = guard;
            default: incr = guard & (round_bit | sticky | mant[0]);
        endcase
        sum        = {1'b0, mant} + {24'd0, incr};
        mant_carry = sum[24];
        mant_out   = mant_carry ? sum[24:1] : sum[23:0];
        inexact    = lost;
    end

endmodule

// File: rtl/fp_norm_round.sv
// Normalises and rounds a raw add/sub result into an IEEE-754 single.
// Define FP_NORM_FAST_LZC_EN for single-cycle left normalisation via leading-zero count.
module fp_norm_round
    import fp_norm_round_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_res,
    input  logic [7:0]  exp_in,
    input  logic        carry,
    input  logic [23:0] mantissa_sum,
    input  logic [23:0] grs,
    input  logic [2:0]  rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [2:0]  flags
);

    state_e             state_q, state_d;
    logic [48:0]        sig_q, norm_sig;
    logic signed [9:0]  exp_q, norm_exp, rnd_exp;
    logic               sign_q;
    logic [2:0]         rm_q;
    logic [31:0]        result_q, rnd_result;
    logic [2:0]         flags_q, rnd_flags;
    logic               norm_done, norm_zero;
    logic [23:0]        mant_out;
    logic               mant_carry, inexact, to_max;
`ifdef FP_NORM_FAST_LZC_EN
    logic [9:0]         lz_ext, lim, shamt;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = NORM;
            NORM:    if (norm_zero) state_d = DONE;
                     else if (norm_done) state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // One normalisation step; left shifts stop at the smallest exponent.
    always_comb begin
        norm_sig  = sig_q;
        norm_exp  = exp_q;
        norm_done = 1'b0;
        norm_zero = 1'b0;
`ifdef FP_NORM_FAST_LZC_EN
        lz_ext = '0;
        lim    = '0;
        shamt  = '0;
`endif
        if (sig_q[48]) begin
            norm_sig  = {1'b0, sig_q[48:2], sig_q[1] | sig_q[0]};
            norm_exp  = exp_q + 10'sd1;
            norm_done = 1'b1;
        end else if (sig_q == '0) begin
            norm_zero = 1'b1;
            norm_done = 1'b1;
        end else if (sig_q[47] || exp_q == 10'sd1) begin
            norm_done = 1'b1;
        end else begin
`ifdef FP_NORM_FAST_LZC_EN
            lz_ext    = {4'd0, lzc48(sig_q[47:0])};
            lim       = $unsigned(exp_q - 10'sd1);
            shamt     = (lz_ext > lim) ? lim : lz_ext;
            norm_sig  = sig_q << shamt;
            norm_exp  = exp_q - $signed(shamt);
            norm_done = 1'b1;
`else
            norm_sig  = {sig_q[47:0], 1'b0};
            norm_exp  = exp_q - 10'sd1;
`endif
        end
    end

    fp_round_incr u_round_incr (
        .mant       (sig_q[47:24]),
        .guard      (sig_q[23]),
        .round_bit  (sig_q[22]),
        .sticky     (|sig_q[21:0]),
        .sign       (sign_q),
        .rm         (rm_q),
        .mant_out   (mant_out),
        .mant_carry (mant_carry),
        .inexact    (inexact)
    );

    // Overflow saturates to max finite when the mode never rounds away in this sign.
    always_comb begin
        rnd_exp   = exp_q + $signed({9'd0, mant_carry});
        to_max    = (rm_q == RM_RTZ) || (rm_q == RM_RDN && !sign_q) ||
                    (rm_q == RM_RUP && sign_q);
        rnd_flags = '0;
        if (rnd_exp >= 10'(EXP_MAX)) begin
            rnd_result         = to_max ? {sign_q, 31'h7F7FFFFF} : {sign_q, 8'hFF, 23'd0};
            rnd_flags[FLAG_OF] = 1'b1;
            rnd_flags[FLAG_NX] = 1'b1;
        end else begin
            rnd_result         = {sign_q, (mant_out[23] ? rnd_exp[7:0] : 8'd0), mant_out[22:0]};
            rnd_flags[FLAG_UF] = ~mant_out[23] & inexact;
            rnd_flags[FLAG_NX] = inexact;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q    <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            rm_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    sig_q  <= {carry, mantissa_sum, grs};
                    exp_q  <= $signed({2'b00, (exp_in == 8'd0) ? 8'd1 : exp_in});
                    sign_q <= sign_res;
                    rm_q   <= rm;
                end
                NORM: begin
                    sig_q <= norm_sig;
                    exp_q <= norm_exp;
                    if (norm_zero) begin
                        result_q <= {rm_q == RM_RDN, 31'd0};
                        flags_q  <= '0;
                    end
                end
                ROUND: begin
                    result_q <= rnd_result;
                    flags_q  <= rnd_flags;
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed, table-driven self-checking bench for fp_norm_round.
module tb_fp_norm_round;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic        carry;
        logic [23:0] mant;
        logic [23:0] grs;
        logic [2:0]  rm;
        logic [31:0] res;
        logic [2:0]  flg;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sign_res = 1'b0;
    logic [7:0]  exp_in = '0;
    logic        carry = 1'b0;
    logic [23:0] mantissa_sum = '0;
    logic [23:0] grs = '0;
    logic [2:0]  rm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [2:0]  flags;

    int   tests = 0;
    int   failures = 0;
    vec_t vecs[$];

    fp_norm_round dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .sign_res     (sign_res),
        .exp_in       (exp_in),
        .carry        (carry),
        .mantissa_sum (mantissa_sum),
        .grs          (grs),
        .rm           (rm),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .flags        (flags)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic s, input logic [7:0] e, input logic c, input logic [23:0] m,
                          input logic [23:0] g, input logic [2:0] r, input logic [31:0] res,
                          input logic [2:0] f, input int lat);
        vec_t v;
        v.sign = s; v.exp = e; v.carry = c; v.mant = m; v.grs = g; v.rm = r;
        v.res = res; v.flg = f;
`ifdef FP_NORM_FAST_LZC_EN
        v.lat = (lat > 2) ? 2 : lat;
`else
        v.lat = lat;
`endif
        vecs.push_back(v);
    endtask

    // Drives one operand, captures it, and counts cycles until out_valid (bounded).
    task automatic applyStimulus(input vec_t v, input string name, output int lat);
        @(negedge clk);
        checkOutput({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        sign_res = v.sign; exp_in = v.exp; carry = v.carry;
        mantissa_sum = v.mant; grs = v.grs; rm = v.rm;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic releaseResult();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int   lat;
        int   saw_valid;
        vec_t v;
        string nm;

        // sign, exp, carry, mantissa, grs, rm, result, flags{OF,UF,NX}, iterative latency
        addVec(0, 8'd127, 1, 24'h000000, 24'h000000, 3'd0, 32'h40000000, 3'b000, 2);
        addVec(0, 8'd127, 0, 24'h000001, 24'h000000, 3'd0, 32'h34000000, 3'b000, 25);
        addVec(0, 8'd127, 0, 24'h000000, 24'h000000, 3'd2, 32'h80000000, 3'b000, 1);
        addVec(0, 8'd127, 0, 24'h000000, 24'h000000, 3'd0, 32'h00000000, 3'b000, 1);
        addVec(0, 8'd127, 0, 24'hFFFFFF, 24'h800000, 3'd0, 32'h40000000, 3'b001, 2);
        addVec(0, 8'd127, 0, 24'hFFFFFF, 24'h800000, 3'd1, 32'h3FFFFFFF, 3'b001, 2);
        addVec(0, 8'd254, 1, 24'h000000, 24'h000000, 3'd0, 32'h7F800000, 3'b101, 2);
        addVec(0, 8'd254, 1, 24'h000000, 24'h000000, 3'd1, 32'h7F7FFFFF, 3'b101, 2);
        addVec(0, 8'd127, 0, 24'h800000, 24'h000000, 3'd0, 32'h3F800000, 3'b000, 2);
        addVec(1, 8'd127, 0, 24'h800000, 24'h000001, 3'd2, 32'hBF800001, 3'b001, 2);
        addVec(1, 8'd127, 0, 24'h800000, 24'h000001, 3'd3, 32'hBF800000, 3'b001, 2);
        addVec(0, 8'd127, 0, 24'h800000, 24'h800000, 3'd4, 32'h3F800001, 3'b001, 2);
        addVec(0, 8'd127, 0, 24'h800000, 24'h800000, 3'd0, 32'h3F800000, 3'b001, 2);
        addVec(0, 8'd127, 0, 24'h800000, 24'h800000, 3'd7, 32'h3F800000, 3'b001, 2);
        addVec(0, 8'd0,   0, 24'h400000, 24'h000000, 3'd0, 32'h00400000, 3'b000, 2);
        addVec(0, 8'd1,   0, 24'h000001, 24'h400000, 3'd0, 32'h00000001, 3'b011, 2);
        addVec(0, 8'd3,   0, 24'h000001, 24'h000000, 3'd0, 32'h00000004, 3'b000, 4);
        addVec(0, 8'd1,   0, 24'h7FFFFF, 24'h800000, 3'd0, 32'h00800000, 3'b001, 2);
        addVec(1, 8'd254, 1, 24'h000000, 24'h000000, 3'd2, 32'hFF800000, 3'b101, 2);
        addVec(1, 8'd254, 1, 24'h000000, 24'h000000, 3'd3, 32'hFF7FFFFF, 3'b101, 2);
        addVec(0, 8'd255, 0, 24'h800000, 24'h000000, 3'd0, 32'h7F800000, 3'b101, 2);
        addVec(0, 8'd127, 0, 24'h400000, 24'h800000, 3'd0, 32'h3F000001, 3'b000, 3);

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_in_ready",  {31'd0, in_ready},  32'd1);
        checkOutput("reset_result",    result,             32'd0);
        checkOutput("reset_flags",     {29'd0, flags},     32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            nm = $sformatf("v%0d", i);
            applyStimulus(vecs[i], nm, lat);
            checkOutput({nm, "_latency"}, 32'(lat), 32'(vecs[i].lat));
            checkOutput({nm, "_result"}, result, vecs[i].res);
            checkOutput({nm, "_flags"}, {29'd0, flags}, {29'd0, vecs[i].flg});
            releaseResult();
        end

        // Result must hold while the consumer stalls.
        v = vecs[8];
        applyStimulus(v, "hold", lat);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("hold%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("hold%0d_result", k), result, 32'h3F800000);
            checkOutput($sformatf("hold%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
        end
        releaseResult();
        checkOutput("hold_release_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset while normalising aborts the operation silently.
        @(negedge clk);
        sign_res = 1'b0; exp_in = 8'd127; carry = 1'b0;
        mantissa_sum = 24'h000001; grs = '0; rm = 3'd0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("abort_in_ready",  {31'd0, in_ready},  32'd1);
        checkOutput("abort_result",    result,             32'd0);
        checkOutput("abort_flags",     {29'd0, flags},     32'd0);
        saw_valid = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid++;
        end
        checkOutput("abort_no_output", 32'(saw_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/fp_norm_round.md
FP_NORM_ROUND -- requirements
Module: fp_norm_round

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  raw add/sub result present.
REQ-004 in_ready  output  1  block can accept; high only in IDLE.
REQ-005 sign_res  input  1  sign of raw sum.
REQ-006 exp_in  input  8  biased exponent of larger operand (0 treated as effective 1).
REQ-007 carry  input  1  mantissa sum overflow bit.
REQ-008 mantissa_sum  input  24  raw sum, bit 23 = hidden-bit position.
REQ-009 grs  input  24  bits below mantissa_sum; bit 23 guard, 22 round, 21:0 sticky.
REQ-010 rm  input  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; others treated as RNE.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  32  packed IEEE-754 single.
REQ-014 flags  output  3  {OF, UF, NX}.

Function
REQ-015 Inputs SHALL be captured into internal registers on in_valid && in_ready; capture moves IDLE->NORM.
REQ-016 Internal exponent SHALL be 10-bit signed; internal significand SHALL be {carry, mantissa_sum, grs} (49 bits).
REQ-017 NORM with carry=1: shift right 1, OR bit shifted out into sticky, exponent+1, go ROUND.
REQ-018 NORM with significand all zero: result = signed zero, sign 1 only when rm=RDN, else 0; flags 0; go DONE.
REQ-019 NORM with bit 23 of mantissa =1, or exponent =1: go ROUND.
REQ-020 NORM otherwise: shift left 1 (grs[23] enters mantissa LSB, 0 enters grs LSB), exponent-1, stay NORM (one bit per cycle).
REQ-021 ROUND: increment decided from guard, round, sticky, LSB, sign and rm per IEEE-754; NX = guard|round|sticky.
REQ-022 Rounding increment carrying out of 24 bits SHALL shift mantissa right 1 and exponent+1.
REQ-023 Exponent >=255 after rounding: OF=1, NX=1; result inf, or max finite 0x7F7FFFFF/0xFF7FFFFF when rm forbids rounding away from zero in that sign direction.
REQ-024 Final mantissa bit 23 =0 at exponent 1: packed exponent 0 (subnormal); UF=1 only if NX=1.
REQ-025 ROUND SHALL go DONE after one cycle.
REQ-026 DONE: out_valid=1, result/flags stable; on out_ready go IDLE same edge; held indefinitely otherwise.
REQ-027 Latency capture->out_valid SHALL be 2 + number of left shifts cycles (carry or no shift: 2).

Reset
REQ-028 reset SHALL force IDLE, out_valid=0, result=0, flags=0, in_ready=1 on next edge, aborting any operation in progress without output.

Configuration
REQ-029 Macro FP_NORM_FAST_LZC_EN defined: NORM SHALL perform full left normalisation in one cycle via leading-zero count clamped to exponent-1; latency fixed 2 cycles.
REQ-030 Macro undefined: iterative one-bit-per-cycle shift of REQ-020; results bit-identical in both builds.

Structure
REQ-031 Shared package SHALL hold rounding-mode enum, FSM state enum (IDLE, NORM, ROUND, DONE), flag bit indices, constants EXP_MAX=255, BIAS=127.
REQ-032 One sub-module fp_round_incr (combinational increment decision and mantissa increment) is natural; FSM and shifter stay in top.

Verification
REQ-033 carry=1, mantissa_sum=0x000000, grs=0, exp_in=127, rm=RNE -> result 0x40000000, flags 0, out_valid 2 cycles after capture.
REQ-034 mantissa_sum=0x000001, grs=0, exp_in=127 -> result 0x34000000, flags 0; latency 25 cycles iterative, 2 with FP_NORM_FAST_LZC_EN.
REQ-035 mantissa_sum=0, grs=0, sign_res=0, rm=RDN -> 0x80000000; rm=RNE -> 0x00000000; flags 0.
REQ-036 mantissa_sum=0xFFFFFF, grs=0x800000, exp_in=127, sign 0, RNE -> 0x40000000, NX=1; RTZ -> 0x3FFFFFFF, NX=1.
REQ-037 carry=1, mantissa_sum=0, exp_in=254, RNE -> 0x7F800000, OF=1, NX=1; RTZ -> 0x7F7FFFFF, OF=1, NX=1.
REQ-038 out_ready held low 5 cycles in DONE -> result stable, in_ready=0; reset asserted mid-NORM -> next cycle IDLE, out_valid=0, no result emitted.
